demux_seq_driver: RTL and testbench

Upstream driver for the 1-to-8 demultiplexer stage. It accepts an 8-bit parallel word over a valid/ready handshake. It then serializes the word LSB-first onto the demux data/enable/select inputs (a, en, s), one channel per bit slot, so that y[i] receives din[i]. It provides a busy flag and a done pulse per word.

---
 rtl/demux_seq_pkg.sv | 17 +
 rtl/demux_seq_driver_if.sv | 27 ++
 rtl/seq_bit_timer.sv | 44 ++++
 rtl/demux_seq_driver.sv | 99 +++++++++
 tb/tb_demux_seq_driver.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/demux_seq_pkg.sv
// Shared definitions for the 1-to-8 demux sequence driver.
//   NCH / SEL_W         : channel count and select width (fixed by the 3-bit demux select)
//   DWELL_MIN/DWELL_MAX : legal range for the per-bit dwell parameter
//   state_e             : driver FSM states
package demux_seq_pkg;

  localparam int unsigned NCH       = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DWELL_MIN = 1;
  localparam int unsigned DWELL_MAX = 16;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/demux_seq_driver_if.sv
// Handshake and demux-side bus of the sequence driver.
//   din/din_valid/din_ready : parallel word input with valid/ready handshake
//   a/en/s                  : serial data, enable and channel select to the demux
//   busy/done               : word in progress / one-cycle pulse in the final bit cycle
// slave  : the driver's view; master : the word producer / demux observer view.
interface demux_seq_driver_if;

  logic [demux_seq_pkg::NCH-1:0]   din;
  logic                            din_valid;
  logic                            din_ready;
  logic                            a;
  logic                            en;
  logic [demux_seq_pkg::SEL_W-1:0] s;
  logic                            busy;
  logic                            done;

  modport slave (
    input  din, din_valid,
    output din_ready, a, en, s, busy, done
  );

  modport master (
    output din, din_valid,
    input  din_ready, a, en, s, busy, done
  );

endinterface

// File: rtl/seq_bit_timer.sv
// Dwell timer for one bit slot.
//   clk, rst     : clock and synchronous active-high reset
//   load_i       : start a fresh slot (new word accepted)
//   run_i        : a word is being shifted
//   tick_o       : current cycle is the last cycle of the current slot
//   last_next_o  : the count in the next cycle will be the last-cycle value
module seq_bit_timer #(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic tick_o,
  output logic last_next_o
);

  localparam int unsigned CntW = ($clog2(DWELL + 1) > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Down counter: counts DWELL-1 .. 0 within a slot, reloads at slot end.
  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = Reload;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = run_i && (cnt_q == '0);
  assign last_next_o = (cnt_d == '0);

endmodule

// File: rtl/demux_seq_driver.sv
// Serializes an 8-bit word LSB-first onto the demux inputs so that channel i receives din[i].
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport (din/din_valid/din_ready in; a/en/s/busy/done out)
// Each (s, a) pair is held DWELL cycles; din_ready is also high in the final cycle of a word
// so that back-to-back words stream without an en=0 gap.
module demux_seq_driver
  import demux_seq_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input logic               clk,
  input logic               rst,
  demux_seq_driver_if.slave bus
);

  if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_dwell_bad
    $fatal(1, "demux_seq_driver: DWELL must be in 1..16");
  end

  state_e           state_q, state_d;
  logic [NCH-1:0]   shreg_q, shreg_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic tick;
  logic last_next;
  logic last_slot;
  logic xfer;

  seq_bit_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (xfer),
    .run_i      (state_q == StShift),
    .tick_o     (tick),
    .last_next_o(last_next)
  );

  assign last_slot     = (state_q == StShift) && (s_q == SEL_W'(NCH - 1)) && tick;
  assign bus.din_ready = (state_q == StIdle) || last_slot;
  assign xfer          = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    s_d     = s_q;
    en_d    = en_q;
    busy_d  = busy_q;
    if (xfer) begin
      state_d = StShift;
      shreg_d = bus.din;
      s_d     = '0;
      en_d    = 1'b1;
      busy_d  = 1'b1;
    end else if ((state_q == StShift) && tick) begin
      // Shifting in a zero means a returns to 0 automatically after bit 7.
      shreg_d = {1'b0, shreg_q[NCH-1:1]};
      if (s_q == SEL_W'(NCH - 1)) begin
        state_d = StIdle;
        s_d     = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end else begin
        s_d = s_q + SEL_W'(1);
      end
    end
    // done is registered, so raise it one cycle ahead of the final cycle.
    done_d = (state_d == StShift) && (s_d == SEL_W'(NCH - 1)) && last_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      s_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      s_q     <= s_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a    = shreg_q[0];
  assign bus.en   = en_q;
  assign bus.s    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_demux_seq_driver.sv
// Bench for demux_seq_driver: one instance with DWELL=1 and one with DWELL=3, both checked every
// cycle against a word/cycle-offset model (slot = offset / DWELL, a = word[slot]).
module tb_demux_seq_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_seq_driver_if bus0 ();
  demux_seq_driver_if bus1 ();

  demux_seq_driver #(
    .DWELL(1)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  demux_seq_driver #(
    .DWELL(3)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: per instance, whether a word is active and how many cycles into it we are.
  int         dw[2] = '{1, 3};
  bit         act[2];
  int         k[2];
  logic [7:0] word[2];
  logic [7:0] y[2];
  logic       v[2];
  logic [7:0] dd[2];
  bit         acc[2];

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %0h expected %0h at %0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic en, input logic busy,
                           input logic done, input logic a, input logic [2:0] s);
    bit         last;
    logic [2:0] es;
    logic       ea;
    last = act[d] && (k[d] == 8 * dw[d] - 1);
    es   = act[d] ? 3'(k[d] / dw[d]) : 3'd0;
    ea   = act[d] ? word[d][k[d] / dw[d]] : 1'b0;
    chk("din_ready", d, rdy, !act[d] || last);
    chk("en", d, en, act[d]);
    chk("busy", d, busy, act[d]);
    chk("s", d, s, es);
    chk("a", d, a, ea);
    chk("done", d, done, last);
    // Behavioural demux: channel s latches a whenever enabled.
    if (en === 1'b1) y[d][s] = a;
    if (last) chk("demux_y", d, y[d], word[d]);
  endtask

  task automatic step(input logic r);
    bit rdy_m[2];
    bus0.din_valid = v[0];
    bus0.din       = dd[0];
    bus1.din_valid = v[1];
    bus1.din       = dd[1];
    rst            = r;
    for (int d = 0; d < 2; d++) rdy_m[d] = !act[d] || (k[d] == 8 * dw[d] - 1);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = 1'b0;
      if (r) begin
        act[d] = 1'b0;
        k[d]   = 0;
      end else if (v[d] && rdy_m[d]) begin
        act[d]  = 1'b1;
        k[d]    = 0;
        word[d] = dd[d];
        y[d]    = 8'h00;
        acc[d]  = 1'b1;
      end else if (act[d]) begin
        if (k[d] == 8 * dw[d] - 1) begin
          act[d] = 1'b0;
          k[d]   = 0;
        end else begin
          k[d]++;
        end
      end
    end
    #1;
    check_dut(0, bus0.din_ready, bus0.en, bus0.busy, bus0.done, bus0.a, bus0.s);
    check_dut(1, bus1.din_ready, bus1.en, bus1.busy, bus1.done, bus1.a, bus1.s);
  endtask

  // Hold din_valid with word w until the model accepts it (bounded).
  task automatic send(input int d, input logic [7:0] w);
    v[d]  = 1'b1;
    dd[d] = w;
    for (int i = 0; i < 200; i++) begin
      step(1'b0);
      if (acc[d]) break;
    end
    chk("accepted", d, acc[d], 1'b1);
    v[d] = 1'b0;
  endtask

  task automatic idle_until(input int d, input int kk);
    for (int i = 0; i < 200; i++) begin
      if (act[d] && k[d] == kk) break;
      step(1'b0);
    end
  endtask

  initial begin
    v[0] = 1'b0; v[1] = 1'b0;
    dd[0] = 8'h00; dd[1] = 8'h00;
    act[0] = 1'b0; act[1] = 1'b0;
    k[0] = 0; k[1] = 0;
    word[0] = 8'h00; word[1] = 8'h00;
    y[0] = 8'h00; y[1] = 8'h00;

    // Reset, then idle.
    step(1'b1);
    step(1'b1);
    repeat (3) step(1'b0);

    // Single word, DWELL=1.
    send(0, 8'hA5);
    repeat (10) step(1'b0);

    // Back-to-back words, valid held high throughout.
    send(0, 8'hFF);
    send(0, 8'h01);
    repeat (10) step(1'b0);

    // DWELL=3, only bit 7 set.
    send(1, 8'h80);
    repeat (28) step(1'b0);

    // New word presented mid-word is held off until the final cycle.
    send(0, 8'h5A);
    idle_until(0, 2);
    send(0, 8'h3C);
    repeat (10) step(1'b0);

    // Reset mid-word, then a clean restart.
    send(0, 8'h77);
    idle_until(0, 4);
    step(1'b1);
    send(0, 8'h0F);
    repeat (10) step(1'b0);

    // Random traffic with occasional resets.
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        v[d]  = 1'($urandom_range(0, 1));
        dd[d] = 8'($urandom);
      end
      step($urandom_range(0, 99) == 0);
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (30) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
